// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared types and constants for the cache miss fill sequencer
//   state_t            sequencer states
//   SEL_I / SEL_D      encoding of the granted cache
//   WORDS_PER_BLOCK    words per 16-byte block, CNT_W its counter width
//   BLOCK_OFFSET_MASK  clears the byte offset within a block
package cache_fill_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;
  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;
endpackage

// File: rtl/fill_word_counter.sv
// fill_word_counter: word index within a block fill
//   clk, rst  clock and synchronous active-high reset
//   clr       return to word 0
//   inc       advance one word
//   count     current word index
//   done      the last word of the block is being counted this cycle
module fill_word_counter
  import cache_fill_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end
  assign done = inc && (count == CNT_W'(WORDS_PER_BLOCK - 1));
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-handling sequencer shared by the I-cache and D-cache
//   i_miss/d_miss, *_miss_addr   held miss requests from each cache
//   mem_en, mem_addr             one pipelined word read per cycle
//   mem_data_valid, mem_data_in  in-order read returns
//   fill_data, fill_addr         write port into the granted cache's data array
//   i_/d_data_wr, i_/d_tag_wr    per-cache data and tag write strobes
//   i_busy, d_busy               fill in progress for that cache
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  d_miss,
  input  logic [ADDR_WIDTH-1:0] d_miss_addr,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  i_data_wr,
  output logic                  d_data_wr,
  output logic                  i_tag_wr,
  output logic                  d_tag_wr,
  output logic                  i_busy,
  output logic                  d_busy
);
  state_t state;
  logic sel;
  logic last_grant;
  logic issuing;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic issue_done;
  logic recv_done;
  logic grant_d;
  logic rx;
  logic idle;
  // D wins unless it won the previous contested-or-not grant while I waits
  assign grant_d = d_miss && (!i_miss || last_grant != SEL_D);
  assign idle = state == IDLE;
  assign rx = state == FILL && mem_data_valid;
  assign mem_en = state == FILL && issuing;
  fill_word_counter u_issue (
    .clk(clk), .rst(rst), .clr(idle), .inc(mem_en), .count(issue_cnt), .done(issue_done)
  );
  fill_word_counter u_recv (
    .clk(clk), .rst(rst), .clr(idle), .inc(rx), .count(recv_cnt), .done(recv_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= SEL_I;
      last_grant <= SEL_I;
      issuing <= 1'b0;
      base <= '0;
    end else begin
      case (state)
        IDLE: if (i_miss || d_miss) begin
          sel <= grant_d;
          last_grant <= grant_d;
          base <= (grant_d ? d_miss_addr : i_miss_addr) & ADDR_WIDTH'(BLOCK_OFFSET_MASK);
          issuing <= 1'b1;
          state <= FILL;
        end
        FILL: begin
          if (issue_done) issuing <= 1'b0;
          if (recv_done) state <= TAG;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // word offsets stay inside the block, so these adds never carry past bit 3
  assign mem_addr = mem_en ? base + ADDR_WIDTH'({issue_cnt, 1'b0}) : '0;
  assign fill_addr = rx ? base + ADDR_WIDTH'({recv_cnt, 1'b0}) : base;
  assign fill_data = mem_data_in;
  assign i_data_wr = rx && sel == SEL_I;
  assign d_data_wr = rx && sel == SEL_D;
  assign i_tag_wr = state == TAG && sel == SEL_I;
  assign d_tag_wr = state == TAG && sel == SEL_D;
  assign i_busy = !idle && sel == SEL_I;
  assign d_busy = !idle && sel == SEL_D;
endmodule
